// File: rtl/brc_seq.sv
// brc_seq: multi-cycle branch comparator.
// Scans two operands CHUNK bits per cycle from the MSB and stops at the
// first differing chunk. It returns registered less/equal/taken flags
// through a valid/ready handshake.

module brc_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic [2:0]       i_funct3,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_br_less,
  output logic             o_br_equal,
  output logic             o_taken,
  output logic             o_busy
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       funct3_q;
  logic [IDXW-1:0]  idx;

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             chunk_less;

  // Branch decision from the compare result; the unused funct3 codes never branch.
  function automatic logic decode_taken(input logic [2:0] f, input logic less,
                                        input logic equal);
    logic t;
    case (f)
      3'b000:         t = equal;
      3'b001:         t = !equal;
      3'b100, 3'b110: t = less;
      3'b101, 3'b111: t = !less;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

  // Signed compares flip both MSBs so a plain unsigned chunk scan gives signed order.
  always_comb begin
    a_in = i_rs1_data;
    b_in = i_rs2_data;
    if (!i_funct3[1]) begin
      a_in[WIDTH-1] = ~i_rs1_data[WIDTH-1];
      b_in[WIDTH-1] = ~i_rs2_data[WIDTH-1];
    end
  end

  // Pick out the chunk currently being examined.
  always_comb begin
    a_shift    = a_q >> (int'(idx) * CHUNK);
    b_shift    = b_q >> (int'(idx) * CHUNK);
    a_chunk    = a_shift[CHUNK-1:0];
    b_chunk    = b_shift[CHUNK-1:0];
    chunk_less = (a_chunk < b_chunk);
  end

  assign o_ready = (state == IDLE);
  assign o_busy  = (state == COMPARE);

  // Control FSM with registered result flags; flush overrides everything but reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      funct3_q   <= '0;
      idx        <= '0;
      o_valid    <= 1'b0;
      o_br_less  <= 1'b0;
      o_br_equal <= 1'b0;
      o_taken    <= 1'b0;
    end else if (i_flush) begin
      state      <= IDLE;
      o_valid    <= 1'b0;
      o_br_less  <= 1'b0;
      o_br_equal <= 1'b0;
      o_taken    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_q      <= a_in;
            b_q      <= b_in;
            funct3_q <= i_funct3;
            idx      <= IDXW'(N - 1);
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          if (a_chunk != b_chunk) begin
            o_br_less  <= chunk_less;
            o_br_equal <= 1'b0;
            o_taken    <= decode_taken(funct3_q, chunk_less, 1'b0);
            o_valid    <= 1'b1;
            state      <= DONE;
          end else if (idx == '0) begin
            o_br_less  <= 1'b0;
            o_br_equal <= 1'b1;
            o_taken    <= decode_taken(funct3_q, 1'b0, 1'b1);
            o_valid    <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/brc_seq.md
# brc_seq

Parametrised, multi-cycle branch comparator for the area-reduced core configuration. It accepts two WIDTH-bit operands and a branch funct3, and scans the operands CHUNK bits per cycle from the MSB, stopping at the first chunk that differs. It returns registered less, equal and taken flags through a valid/ready handshake. It sits between the register-file read stage and the PC-select logic, and it replaces the single-cycle combinational comparator when WIDTH is large or timing is tight.

## Interface
Parameters:
- WIDTH, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; power of two, 1 ≤ CHUNK ≤ WIDTH.
- N (localparam), WIDTH/CHUNK, number of chunks.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request; high exactly when state is IDLE.
- i_rs1_data  in  WIDTH  operand A.
- i_rs2_data  in  WIDTH  operand B.
- i_funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- i_flush  in  1  abort any in-flight or pending result.
- o_valid  out  1  result valid; held until accepted.
- i_ready  in  1  consumer accepts the result.
- o_br_less  out  1  A < B; signed for funct3[1]=0, unsigned for funct3[1]=1.
- o_br_equal  out  1  A == B.
- o_taken  out  1  branch decision for the captured funct3.
- o_busy  out  1  state is COMPARE.

## Operation
- States: IDLE, COMPARE, DONE.
- IDLE:
  - On i_valid && o_ready && !i_flush, capture the operands and funct3, set the chunk index to N-1, and go to COMPARE.
- Signed mode: invert the MSB of both captured operands at capture. The unsigned chunk compare then yields the signed order.
- COMPARE: each cycle, compare chunk[idx] of A and B as unsigned values.
  - If the chunks differ: less = (a_chunk < b_chunk), equal = 0, go to DONE (early exit).
  - If the chunks are equal and idx == 0: less = 0, equal = 1, go to DONE.
  - Otherwise decrement idx and stay in COMPARE.
- taken decode:
  - BEQ: equal. BNE: !equal.
  - BLT and BLTU: less. BGE and BGEU: !less.
  - funct3 010 or 011: taken = 0; less and equal are still reported (unsigned).
- DONE:
  - o_valid = 1. o_br_less, o_br_equal and o_taken are registered and stable.
  - On i_ready, go to IDLE and clear o_valid.
- The block does not accept a new request in the DONE cycle; o_ready is low outside IDLE.
- i_flush in any state: go to IDLE next edge, clear o_valid, o_br_less, o_br_equal and o_taken. Flush has priority over accept and over i_ready.
- Reset (asynchronous, any state): state = IDLE, idx = 0, operand registers = 0, and every output register = 0.
- Reset values of outputs: o_valid 0, o_br_less 0, o_br_equal 0, o_taken 0, o_busy 0, o_ready 1 (state is IDLE).

## Timing
- Cycle 0: the accept edge. Cycles 1..k are in COMPARE, where k = 1 + number of leading equal chunks, with 1 ≤ k ≤ N.
- o_valid rises at the edge ending cycle k, so it is visible in cycle k+1.
- Latency from accept to o_valid is k+1 cycles. Minimum is 2. Maximum is N+1 (5 for 32/8).
- Throughput: one request per k+2 cycles with i_ready tied high. The result is held indefinitely under back-pressure.
- Inputs other than i_valid, i_flush and i_ready are ignored outside the accept cycle.
- When o_valid, i_ready and i_flush are high together, the flush wins: the result is discarded and counts as not consumed.

## Test plan
- Reset and idle:
  - Stimulus: assert i_reset low mid-COMPARE.
  - Required: all outputs 0 and o_ready 1 immediately. After release, a request is accepted on the first i_valid.
- Early exit, WIDTH=32, CHUNK=8:
  - Stimulus: A=0x8000_0000, B=0x0000_0001, funct3=100 (BLT).
  - Required: o_valid in cycle 2, o_br_less=1, o_taken=1. With funct3=110 (BLTU): o_br_less=0, o_taken=0.
- Full scan:
  - Stimulus: A=B=0xDEAD_BEEF, funct3=000 (BEQ).
  - Required: o_busy for 4 cycles, o_valid in cycle 5, o_br_equal=1, o_taken=1. With funct3=001 (BNE): o_taken=0.
- Last-chunk difference:
  - Stimulus: A=0xFFFF_FFFE, B=0xFFFF_FFFF, funct3=101 (BGE).
  - Required: 4 compare cycles, less=1, equal=0, taken=0.
- Back-pressure and flush:
  - Stimulus: hold i_ready=0 for 10 cycles.
  - Required: outputs stable and o_ready=0 throughout.
  - Then assert i_flush together with i_ready. Required: o_valid drops next cycle and the result is not counted as consumed.
  - Stimulus: i_flush with i_valid in IDLE. Required: no capture.
- Parameter sweep:
  - Stimulus: CHUNK ∈ {1, 4, 32} with WIDTH=32; random operands and all six funct3 values against a reference model.
  - Required: flags match the model, and latency equals 1 + leading-equal-chunk count + 1.
